// File: rtl/ntt_cmd_dispatcher.sv
// Command FIFO + strictly serialised issue sequencer in front of an NTT engine core.
// Optional opcode legality checking is enabled by defining NTT_DISP_OPCHECK_EN.
module ntt_cmd_dispatcher #(
    parameter int DEPTH   = 16,
    parameter int CORE_ID = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [63:0]             in_data,
    input  logic                    pause,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_opcode,
    output logic [3:0]              cmd_slot,
    output logic [47:0]             cmd_dma_addr,
    input  logic                    eng_ready,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [31:0]             issued_count,
    output logic                    err_illegal,
    input  logic                    err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam int UNUSED_CORE_ID = CORE_ID;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    // Entries keep opcode, slot and address; the reserved nibble is not stored.
    logic [59:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [1:0]    state_reg;
    logic          cmd_valid_reg;
    logic [7:0]    opcode_reg;
    logic [3:0]    slot_reg;
    logic [47:0]   addr_reg;
    logic [31:0]   issued_reg;

    logic [59:0]   head;
    logic [7:0]    head_op;
    logic          head_illegal;
    logic          examine;
    logic          drop;
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_rsvd;

    assign unused_rsvd = ^in_data[51:48];

    assign in_ready = (level_reg < FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr_reg];
    assign head_op  = head[59:52];

    // Only S_IDLE looks at the head; NOPs and rejected opcodes retire without the engine.
    assign examine = (state_reg == S_IDLE) && (level_reg != '0) && !pause;
    assign drop    = examine && ((head_op == 8'h00) || head_illegal);
    assign issue   = examine && !drop && eng_ready;
    assign pop     = drop || issue;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_data[63:52], in_data[47:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cmd_valid_reg <= 1'b0;
            opcode_reg    <= '0;
            slot_reg      <= '0;
            addr_reg      <= '0;
            issued_reg    <= '0;
        end else begin
            cmd_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (issue) begin
                        state_reg     <= S_WAIT_BUSY;
                        cmd_valid_reg <= 1'b1;
                        opcode_reg    <= head[59:52];
                        slot_reg      <= head[51:48];
                        addr_reg      <= head[47:0];
                        issued_reg    <= issued_reg + 1'b1;
                    end
                end
                // Wait for the engine to visibly take the command before waiting for completion.
                S_WAIT_BUSY: if (!eng_ready) state_reg <= S_WAIT_DONE;
                S_WAIT_DONE: if (eng_ready)  state_reg <= S_IDLE;
                default:     state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef NTT_DISP_OPCHECK_EN
    logic err_reg;

    always_comb begin
        case (head_op)
            8'h00, 8'h02, 8'h03, 8'h04, 8'h0F,
            8'h10, 8'h11, 8'h20, 8'h21, 8'h22: head_illegal = 1'b0;
            default:                           head_illegal = 1'b1;
        endcase
    end

    // Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (drop && head_illegal) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign err_illegal = err_reg;
`else
    logic unused_err_clr;

    assign head_illegal   = 1'b0;
    assign err_illegal    = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    assign cmd_valid    = cmd_valid_reg;
    assign cmd_opcode   = opcode_reg;
    assign cmd_slot     = slot_reg;
    assign cmd_dma_addr = addr_reg;
    assign issued_count = issued_reg;
    assign fifo_level   = level_reg;
    assign busy         = (level_reg != '0) || (state_reg != S_IDLE);

endmodule

// File: tb/tb_ntt_cmd_dispatcher.sv
// Self-checking bench for ntt_cmd_dispatcher: in-order expected-command queue plus a simple engine model.
`timescale 1ns/1ps
module tb_ntt_cmd_dispatcher;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [63:0]            in_data;
    logic                   pause;
    logic                   cmd_valid;
    logic [7:0]             cmd_opcode;
    logic [3:0]             cmd_slot;
    logic [47:0]            cmd_dma_addr;
    logic                   eng_ready = 1'b1;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [31:0]            issued_count;
    logic                   err_illegal;
    logic                   err_clr;

    ntt_cmd_dispatcher #(.DEPTH(DEPTH), .CORE_ID(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pause(pause), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_slot(cmd_slot),
        .cmd_dma_addr(cmd_dma_addr), .eng_ready(eng_ready), .busy(busy), .fifo_level(fifo_level),
        .issued_count(issued_count), .err_illegal(err_illegal), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q [$];
    int  exp_total = 0;
    int  seen_total = 0;
    bit  err_exp = 0;
    int  cyc = 0;
    int  last_issue_cyc = -100;
    bit  prev_cv = 0;
    bit  eng_hold = 0;
    int  eng_len = 1;
    int  eng_cnt = 0;
    bit  eng_pend = 0;
    bit  last_acc;
    int  push_cyc;
    int  acc_n;
    logic [7:0] legal_ops [10] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit expect_issue(input logic [7:0] op);
        if (op == 8'h00) return 1'b0;
`ifdef NTT_DISP_OPCHECK_EN
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] gen_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'($urandom_range(0, 255));
        return legal_ops[$urandom_range(1, 9)];
    endfunction

    // Engine: sees cmd_valid, drops ready one cycle later for eng_len cycles.
    always @(negedge clk) begin
        if (rst) begin
            eng_pend = 0;
            eng_cnt  = 0;
        end else begin
            if (eng_cnt > 0) eng_cnt--;
            if (eng_pend) begin
                eng_pend = 0;
                eng_cnt  = eng_len;
            end
            if (cmd_valid) eng_pend = 1;
        end
        eng_ready = !eng_hold && (eng_cnt == 0);
    end

    // Issue monitor: each pulse must match the oldest expected command.
    always @(negedge clk) begin
        logic [63:0] w;
        if (rst) begin
            prev_cv = 0;
            last_issue_cyc = -100;
            seen_total = 0;
        end else begin
            if (cmd_valid) begin
                check("no_back_to_back", prev_cv, 0);
                check("issue_spacing", (cyc - last_issue_cyc) >= 4, 1);
                check("issue_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("issue_opcode", cmd_opcode, w[63:56]);
                    check("issue_slot", cmd_slot, w[55:52]);
                    check("issue_addr", cmd_dma_addr, w[47:0]);
                end
                seen_total++;
                check("issue_count", issued_count, seen_total);
                last_issue_cyc = cyc;
                $display("[TB] issue %0d op=%02h slot=%0h addr=%012h", seen_total, cmd_opcode, cmd_slot, cmd_dma_addr);
            end
            prev_cv = cmd_valid;
        end
    end

    task automatic drive(input bit v, input logic [63:0] d);
        in_valid = v;
        in_data  = d;
        last_acc = v && in_ready;
        @(posedge clk); #1;
        in_valid = 0;
        if (last_acc) begin
            if (expect_issue(d[63:56])) begin
                exp_q.push_back(d);
                exp_total++;
            end else if (d[63:56] != 8'h00) begin
                err_exp = 1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || !eng_ready) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; pause = 0; err_clr = 0; eng_hold = 0; eng_len = 1;
        exp_q.delete(); exp_total = 0; err_exp = 0;
        repeat (3) @(posedge clk);
        #1; rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_issued"}, issued_count, 0);
        check({tag, "_err"}, err_illegal, 0);
        check({tag, "_opcode"}, cmd_opcode, 0);
        check({tag, "_slot"}, cmd_slot, 0);
        check({tag, "_addr"}, cmd_dma_addr, 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; pause = 0; err_clr = 0;
        #1;
        check_reset_outputs("reset");
        do_reset();

        // Single issue and first-command latency
        drive(1, 64'h1000_0000_0000_0000);
        push_cyc = cyc;
        wait_idle();
        check("single_latency", last_issue_cyc - push_cyc, 1);
        check("single_count", issued_count, 1);
        check("single_opcode", cmd_opcode, 8'h10);
        check("single_slot", cmd_slot, 0);

        // Back-to-back pushes queue up while the engine is held busy
        eng_hold = 1;
        drive(1, 64'h0210_0000_1111_2222);
        check("b2b_level1", fifo_level, 1);
        drive(1, 64'h1020_0000_3333_4444);
        check("b2b_level2", fifo_level, 2);
        drive(1, 64'h0330_0000_5555_6666);
        check("b2b_level3", fifo_level, 3);
        eng_hold = 0;
        wait_idle();
        check("b2b_level0", fifo_level, 0);
        check("b2b_count", issued_count, exp_total);

        // Full FIFO and pointer wrap
        for (int rep = 0; rep < 2; rep++) begin
            eng_hold = 1;
            acc_n = 0;
            for (int i = 0; i < 17; i++) begin
                drive(1, {legal_ops[1 + (i % 9)], 4'(i), 4'h0, 48'({$urandom(), $urandom()})});
                acc_n += int'(last_acc);
            end
            check("full_accepts", acc_n, DEPTH);
            check("full_level", fifo_level, DEPTH);
            check("full_in_ready", in_ready, 0);
            eng_hold = 0;
            wait_idle();
            check("full_drain_count", issued_count, exp_total);
            check("full_q_empty", exp_q.size(), 0);
        end

        // NOP and pause
        do_reset();
        pause = 1;
        drive(1, 64'h0000_0000_0000_0000);
        drive(1, 64'h2070_0000_0000_00AB);
        repeat (3) begin @(posedge clk); #1; end
        check("pause_level", fifo_level, 2);
        check("pause_no_issue", issued_count, 0);
        pause = 0;
        @(posedge clk); #1;
        check("nop_level", fifo_level, 1);
        check("nop_no_valid", cmd_valid, 0);
        @(posedge clk); #1;
        check("after_nop_valid", cmd_valid, 1);
        check("after_nop_opcode", cmd_opcode, 8'h20);
        wait_idle();
        check("nop_count", issued_count, 1);

        // Illegal opcode handling
        drive(1, 64'h5550_0000_0000_0055);
        drive(1, 64'h1160_0000_0000_0011);
        wait_idle();
        check("illegal_err", err_illegal, err_exp);
        check("illegal_count", issued_count, exp_total);
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        err_exp = 0;
        check("err_clear", err_illegal, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            pause   = ($urandom_range(0, 4) == 0);
            eng_len = $urandom_range(1, 3);
            drive(1'($urandom_range(0, 1)),
                  {gen_op(), 4'($urandom), 4'($urandom), 48'({$urandom(), $urandom()})});
        end
        pause = 0;
        wait_idle();
        check("rand_count", issued_count, exp_total);
        check("rand_q_empty", exp_q.size(), 0);
        check("rand_err", err_illegal, err_exp);

        // Reset while waiting for the engine to finish, with entries queued
        do_reset();
        eng_len = 30;
        drive(1, 64'h0200_0000_0000_0001);
        drive(1, 64'h0300_0000_0000_0002);
        drive(1, 64'h0400_0000_0000_0003);
        drive(1, 64'h1000_0000_0000_0004);
        repeat (4) begin @(posedge clk); #1; end
        check("mid_level", fifo_level, 3);
        check("mid_busy", busy, 1);
        rst = 1;
        #1;
        exp_q.delete(); exp_total = 0; err_exp = 0; eng_len = 1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1; rst = 0;
        repeat (20) begin @(posedge clk); #1; end
        check("post_reset_count", issued_count, 0);
        check("post_reset_level", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ntt_cmd_dispatcher.md
# ntt_cmd_dispatcher

Command queue and issue sequencer that sits directly upstream of an NTT engine core. It accepts 64-bit instruction words from the host/controller, buffers them in a FIFO, decodes each into opcode/slot/DMA-address fields, and issues them one at a time on the engine's `cmd_valid`/`ready` handshake. It strictly serialises commands: an instruction is issued only after the engine has visibly accepted and then completed the previous one.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.
- `CORE_ID`, 0: core index, informational only.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: host instruction valid.
- `in_ready` output 1: FIFO can accept a word; equals `level < DEPTH`.
- `in_data` input 64: instruction word. Fields: [63:56] opcode, [55:52] slot, [51:48] reserved (ignored), [47:0] DMA address.
- `pause` input 1: when high, no new instruction is popped; the in-flight command completes.
- `cmd_valid` output 1: one-cycle issue pulse to the engine.
- `cmd_opcode` output 8: registered opcode.
- `cmd_slot` output 4: registered slot.
- `cmd_dma_addr` output 48: registered DMA address.
- `eng_ready` input 1: engine ready/idle.
- `busy` output 1: high when the FIFO is non-empty or the FSM is not in S_IDLE.
- `fifo_level` output $clog2(DEPTH)+1: current occupancy.
- `issued_count` output 32: number of commands issued since reset; wraps at 2^32.
- `err_illegal` output 1: sticky illegal-opcode flag (see Configuration).
- `err_clr` input 1: clears `err_illegal`.

## Operation
- **FIFO.** Circular buffer with $clog2(DEPTH)-bit read/write pointers that wrap naturally.
  - Push when `in_valid && in_ready`.
  - Pop only from S_IDLE, per the rules below.
  - Push and pop in the same cycle: level unchanged. This cannot occur when full, because `in_ready` is low then.
- **FSM states.**
  - **S_IDLE.** If FIFO non-empty and `pause`=0, examine the head entry:
    - Opcode 0x00 (NOP): pop and discard; stay in S_IDLE. This does not depend on `eng_ready`. At most one NOP is consumed per cycle.
    - Illegal opcode, only with `NTT_DISP_OPCHECK_EN`: pop and discard, set `err_illegal`, stay in S_IDLE.
    - Otherwise, if `eng_ready`=1: pop, register the fields onto `cmd_opcode`/`cmd_slot`/`cmd_dma_addr`, set `cmd_valid`<=1, increment `issued_count`, go to S_WAIT_BUSY.
    - Otherwise (`eng_ready`=0): hold the head entry; no pop.
  - **S_WAIT_BUSY.** `cmd_valid`<=0. Go to S_WAIT_DONE on the first sampled `eng_ready`=0.
  - **S_WAIT_DONE.** Go to S_IDLE on the first sampled `eng_ready`=1.
- `cmd_opcode`/`cmd_slot`/`cmd_dma_addr` hold their last issued values between issues.
- `err_illegal`: set wins over `err_clr` when both occur in the same cycle.

## Timing
- **Reset values.** `cmd_valid`=0, `cmd_opcode`=0, `cmd_slot`=0, `cmd_dma_addr`=0, `issued_count`=0, `err_illegal`=0, `fifo_level`=0, `busy`=0, state=S_IDLE. `in_ready`=1 during and after reset.
- **Reset mid-operation.** All FIFO contents are lost; any in-flight wait is abandoned. No `cmd_valid` is produced during reset.
- **Latency.** A word pushed at edge E into an empty FIFO, with the engine ready, gives `cmd_valid` high after edge E+1.
- **Handshake sequence.**
  - The engine samples `cmd_valid` at edge T+1 and drops `ready` after T+1.
  - The dispatcher observes `eng_ready`=0 at edge T+2 and enters S_WAIT_DONE.
  - Minimum issue-to-issue spacing is therefore 4 cycles, for an engine whose ready drops for one cycle.
- `cmd_valid` is never high for two consecutive cycles.
- `in_ready` is combinational from the registered level only, with no path from `in_valid`.
- `busy` is combinational from the level and the state.

## Configuration
- **`NTT_DISP_OPCHECK_EN` defined.**
  - Legal opcodes: 0x00, 0x02, 0x03, 0x04, 0x0F, 0x10, 0x11, 0x20, 0x21, 0x22.
  - Any other opcode is dropped in S_IDLE, sets sticky `err_illegal`, and does not increment `issued_count`.
- **Undefined.**
  - All non-NOP opcodes are forwarded unchanged.
  - `err_illegal` is tied to 0 and `err_clr` is ignored.

## Test plan
- **Single issue.** Reset, push 0x10_0_0_000000000000 with `eng_ready`=1 held, model ready dropping one cycle after `cmd_valid`.
  - `cmd_valid` pulses once, with `cmd_opcode`=0x10 and `cmd_slot`=0.
  - `issued_count`=1; `busy` falls after ready returns.
- **Back-to-back.** Push opcodes 0x02, 0x10, 0x03 in consecutive cycles.
  - Three pulses, issued in order.
  - Each pulse comes only after ready has fallen and risen; spacing ≥4 cycles.
  - `fifo_level` goes 1, 2, 3, then drains to 0.
- **Full/wrap.** Hold `eng_ready`=0 and push 17 words with DEPTH=16.
  - `in_ready` goes low at level 16 and the 17th word is not accepted.
  - Release ready: exactly 16 issues in order.
  - Repeat to exercise pointer wrap.
- **NOP and pause.**
  - Push 0x00, 0x20 with `pause`=1: no issue.
  - Deassert `pause`: the NOP is consumed in 1 cycle without `cmd_valid`; then 0x20 issues; `issued_count`=1.
- **Illegal opcode (macro on).** Push 0x55 then 0x11.
  - `err_illegal`=1 and 0x55 is never issued; 0x11 issues.
  - `err_clr` returns `err_illegal` to 0.
  - With the macro off, 0x55 is issued.
- **Reset mid-command.** Assert `rst` while in S_WAIT_DONE with 3 entries queued.
  - All outputs return to reset values immediately.
  - No issue occurs after reset deasserts.
